// File: rtl/button_conditioner_pkg.sv
// Shared helpers for the push-button conditioning path.
// Counter widths are derived from the cycle counts so that each counter can hold its terminal value.
package button_conditioner_pkg;

   // Number of bits needed to hold values 0..n, with a floor of 1 bit
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button lane: 2-flop synchronizer, debounce filter, edge pulses and long-press timer.
// The release pulse port is named release_ because "release" is a reserved word.
module button_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 120000,
   parameter int LONG_PRESS_CYCLES = 12000000
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic btn,
   output logic state,
   output logic press,
   output logic release_,
   output logic long_press
);

   localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

   logic [1:0]        sync_ff;
   logic              sync;
   logic [DB_W-1:0]   db_cnt,   db_cnt_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              state_nxt;
   logic              press_nxt;
   logic              release_nxt;
   logic              long_press_nxt;
   logic              accept;

   assign sync = sync_ff[1];

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[0], btn};
      end
   end

   // A differing level is accepted only after an unbroken run of DEBOUNCE_CYCLES;
   // any return to the current level throws away the partial count.
   always_comb begin
      accept      = 1'b0;
      db_cnt_nxt  = '0;
      state_nxt   = state;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      if (sync != state) begin
         if (db_cnt == DB_LAST) begin
            accept      = 1'b1;
            state_nxt   = sync;
            press_nxt   = sync;
            release_nxt = ~sync;
         end else begin
            db_cnt_nxt = db_cnt + 1'b1;
         end
      end
   end

   // hold_cnt is zero while released, so it reads zero in the press cycle and
   // reaches HOLD_MAX exactly LONG_PRESS_CYCLES edges later, then sticks there.
   always_comb begin
      hold_cnt_nxt   = '0;
      long_press_nxt = 1'b0;
      if (state) begin
         hold_cnt_nxt = hold_cnt;
         if (hold_cnt != HOLD_MAX) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
         end
         long_press_nxt = (hold_cnt == HOLD_LAST);
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt     <= '0;
         hold_cnt   <= '0;
         state      <= 1'b0;
         press      <= 1'b0;
         release_   <= 1'b0;
         long_press <= 1'b0;
      end else begin
         db_cnt     <= db_cnt_nxt;
         hold_cnt   <= hold_cnt_nxt;
         state      <= state_nxt;
         press      <= press_nxt;
         release_   <= release_nxt;
         long_press <= long_press_nxt;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions WIDTH raw asynchronous buttons into debounced levels plus press/release/long-press pulses.
// Lanes are fully independent; every output comes straight from a flop.
module button_conditioner #(
   parameter int WIDTH             = 2,
   parameter int DEBOUNCE_CYCLES   = 120000,
   parameter int LONG_PRESS_CYCLES = 12000000
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] BTN,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_,
   output logic [WIDTH-1:0] long_press
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
   end
   if (LONG_PRESS_CYCLES < 1) begin : g_bad_long_press
      $error("button_conditioner: LONG_PRESS_CYCLES must be at least 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
      ) u_ch (
         .CLK        (CLK),
         .reset_n    (reset_n),
         .btn        (BTN[i]),
         .state      (state[i]),
         .press      (press[i]),
         .release_   (release_[i]),
         .long_press (long_press[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected output vectors are queued per cycle as stimulus is driven.
module tb_button_conditioner;

   localparam int W = 2;
   localparam int D = 4;
   localparam int L = 10;

   logic         CLK = 1'b0;
   logic         reset_n;
   logic [W-1:0] BTN;
   logic [W-1:0] state, press, rls, lp;

   always #5 CLK = ~CLK;

   button_conditioner #(
      .WIDTH             (W),
      .DEBOUNCE_CYCLES   (D),
      .LONG_PRESS_CYCLES (L)
   ) dut (
      .CLK        (CLK),
      .reset_n    (reset_n),
      .BTN        (BTN),
      .state      (state),
      .press      (press),
      .release_   (rls),
      .long_press (lp)
   );

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   exp_t mon_e;

   function automatic logic [7:0] pk(input logic [1:0] st, pr, rl, lo);
      return {st, pr, rl, lo};
   endfunction

   // Sorted insert so entries from overlapping phases pop in cycle order
   task automatic expect_at(input int c, input string tag, input logic [1:0] st, pr, rl, lo);
      exp_t e;
      int   i;
      e.cyc = c; e.tag = tag; e.exp = pk(st, pr, rl, lo);
      i = q.size();
      while (i > 0 && q[i-1].cyc > c) i--;
      q.insert(i, e);
   endtask

   task automatic expect_quiet(input int c0, input int c1, input string tag, input logic [1:0] st);
      for (int c = c0; c <= c1; c++) expect_at(c, tag, st, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge CLK);
   endtask

   // Monitor: compare every queued expectation in the cycle it is due (late entries also fail)
   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         checks++;
         assert (mon_e.cyc == cyc && pk(state, press, rls, lp) === mon_e.exp)
            else begin
               errors++;
               $error("FAIL %s @%0d (now %0d): observed %h expected %h",
                      mon_e.tag, mon_e.cyc, cyc, pk(state, press, rls, lp), mon_e.exp);
            end
      end
   end

   initial begin
      int c, p;

      // Reset held with both buttons down
      reset_n = 1'b0;
      BTN     = 2'b11;
      repeat (3) @(negedge CLK);
      chk("reset_hold", pk(state, press, rls, lp), 8'h00);
      reset_n = 1'b1;
      c = cyc;
      expect_quiet(c + 1, c + 5, "rst_pre", 2'b00);
      expect_at(c + 6,  "rst_press",     2'b11, 2'b11, 2'b00, 2'b00);
      expect_quiet(c + 7, c + 15, "rst_hold", 2'b11);
      expect_at(c + 16, "rst_long",      2'b11, 2'b00, 2'b00, 2'b11);
      expect_at(c + 17, "rst_long_end",  2'b11, 2'b00, 2'b00, 2'b00);
      wait_until(c + 18);
      BTN = 2'b00;
      c = cyc;
      expect_at(c + 6, "rel_all", 2'b00, 2'b00, 2'b11, 2'b00);
      expect_quiet(c + 7, c + 8, "rel_all_end", 2'b00);
      wait_until(c + 9);

      // Clean press on button 0, held well past the long-press point
      BTN = 2'b01;
      c = cyc;
      p = c + 6;
      expect_quiet(c + 1, p - 1, "p0_pre", 2'b00);
      expect_at(p, "p0_press", 2'b01, 2'b01, 2'b00, 2'b00);
      expect_quiet(p + 1, p + 9, "p0_hold", 2'b01);
      expect_at(p + 10, "p0_long", 2'b01, 2'b00, 2'b00, 2'b01);
      expect_quiet(p + 11, p + 40, "p0_no_relong", 2'b01);
      wait_until(p + 40);
      BTN = 2'b00;
      c = cyc;
      expect_at(c + 6, "p0_release", 2'b00, 2'b00, 2'b01, 2'b00);
      expect_quiet(c + 7, c + 9, "p0_idle", 2'b00);
      wait_until(c + 10);

      // Bouncing button 1: 3-cycle levels must be filtered out
      c = cyc;
      expect_quiet(c + 1, c + 17, "bnc_quiet", 2'b00);
      expect_at(c + 18, "bnc_press", 2'b10, 2'b10, 2'b00, 2'b00);
      expect_quiet(c + 19, c + 27, "bnc_hold", 2'b10);
      expect_at(c + 28, "bnc_long", 2'b10, 2'b00, 2'b00, 2'b10);
      for (int k = 0; k < 4; k++) begin
         BTN = (k % 2 == 0) ? 2'b10 : 2'b00;
         repeat (3) @(negedge CLK);
      end
      BTN = 2'b10;
      wait_until(c + 29);
      BTN = 2'b00;
      c = cyc;
      expect_at(c + 6, "bnc_release", 2'b00, 2'b00, 2'b10, 2'b00);
      expect_quiet(c + 7, c + 9, "bnc_idle", 2'b00);
      wait_until(c + 10);

      // Short press: release lands 8 cycles after press, no long press
      BTN = 2'b01;
      c = cyc;
      expect_at(c + 6, "sp_press", 2'b01, 2'b01, 2'b00, 2'b00);
      expect_quiet(c + 7, c + 13, "sp_hold", 2'b01);
      expect_at(c + 14, "sp_release", 2'b00, 2'b00, 2'b01, 2'b00);
      expect_quiet(c + 15, c + 25, "sp_no_long", 2'b00);
      wait_until(c + 8);
      BTN = 2'b00;
      wait_until(c + 26);

      // Independence: both pressed together, only button 1 released
      BTN = 2'b11;
      c = cyc;
      expect_at(c + 6, "ind_press", 2'b11, 2'b11, 2'b00, 2'b00);
      expect_quiet(c + 7, c + 13, "ind_hold", 2'b11);
      expect_at(c + 14, "ind_release", 2'b01, 2'b00, 2'b10, 2'b00);
      expect_at(c + 15, "ind_after", 2'b01, 2'b00, 2'b00, 2'b00);
      expect_at(c + 16, "ind_long0", 2'b01, 2'b00, 2'b00, 2'b01);
      expect_at(c + 17, "ind_long_end", 2'b01, 2'b00, 2'b00, 2'b00);
      wait_until(c + 8);
      BTN = 2'b01;
      wait_until(c + 18);
      BTN = 2'b00;
      c = cyc;
      expect_at(c + 6, "ind_release0", 2'b00, 2'b00, 2'b01, 2'b00);
      wait_until(c + 8);

      // Asynchronous reset 5 cycles into a hold, then re-acceptance
      BTN = 2'b01;
      c = cyc;
      p = c + 6;
      expect_at(p, "rmh_press", 2'b01, 2'b01, 2'b00, 2'b00);
      expect_quiet(p + 1, p + 5, "rmh_hold", 2'b01);
      wait_until(p + 5);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rmh_async_clear", pk(state, press, rls, lp), 8'h00);
      repeat (2) @(negedge CLK);
      chk("rmh_in_reset", pk(state, press, rls, lp), 8'h00);
      reset_n = 1'b1;
      c = cyc;
      expect_quiet(c + 1, c + 5, "rmh_pre", 2'b00);
      expect_at(c + 6, "rmh_repress", 2'b01, 2'b01, 2'b00, 2'b00);
      expect_quiet(c + 7, c + 15, "rmh_no_early_long", 2'b01);
      expect_at(c + 16, "rmh_long", 2'b01, 2'b00, 2'b00, 2'b01);
      wait_until(c + 17);
      BTN = 2'b00;

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge CLK);
      checks++;
      assert (q.size() == 0)
         else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", q.size());
         end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
